// File: rtl/arm_pkg.sv
// ----------------------------------------------------------------------------
// arm_pkg
//   Shared definitions for the multicycle ARM control unit.
//   Holds the FSM state enum, ALUControl encodings, datapath mux encodings,
//   data-processing command codes, condition codes and the ALU decoder.
//   No ports (package).
// ----------------------------------------------------------------------------
package arm_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_FAULT
   } state_t;

   // ALUControl encodings; a 2-bit build uses only the low four values.
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_EOR = 3'b100,
      ALU_BIC = 3'b101,
      ALU_MOV = 3'b110
   } alu_op_t;

   localparam logic [1:0] SRCA_REG      = 2'b00;
   localparam logic [1:0] SRCA_PC       = 2'b01;

   localparam logic [1:0] SRCB_WDATA    = 2'b00;
   localparam logic [1:0] SRCB_IMM      = 2'b01;
   localparam logic [1:0] SRCB_FOUR     = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;
   localparam logic [3:0] CMD_BIC = 4'b1110;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
      COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
      COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
      COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
   } cond_t;

   // Data-processing command to ALU operation. The extended ops exist only in
   // wide builds; otherwise they, like any unlisted command, fall back to ADD.
   function automatic alu_op_t alu_decode(input logic [3:0] cmd, input logic wide);
      alu_decode = ALU_ADD;
      case (cmd)
         CMD_ADD:          alu_decode = ALU_ADD;
         CMD_SUB, CMD_CMP: alu_decode = ALU_SUB;
         CMD_AND:          alu_decode = ALU_AND;
         CMD_ORR:          alu_decode = ALU_ORR;
         CMD_EOR:          alu_decode = wide ? ALU_EOR : ALU_ADD;
         CMD_BIC:          alu_decode = wide ? ALU_BIC : ALU_ADD;
         CMD_MOV:          alu_decode = wide ? ALU_MOV : ALU_ADD;
         default:          alu_decode = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// ----------------------------------------------------------------------------
// arm_mc_controller_if
//   Control bundle between the multicycle controller and the datapath/memory.
//   master : controller side (drives control pins, reads Instr/ALUFlags/MemReady)
//   slave  : datapath side
//   Signals: Instr[31:12], ALUFlags (N,Z,C,V), MemReady, MemReq, PCWrite,
//            MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
//            ResultSrc, ImmSrc, ALUControl[ALUCTL_W], LinkWrite, Fault.
// ----------------------------------------------------------------------------
interface arm_mc_controller_if #(
   parameter int ALUCTL_W = 3
);
   logic [31:12]         Instr;
   logic [3:0]           ALUFlags;
   logic                 MemReady;
   logic                 MemReq;
   logic                 PCWrite;
   logic                 MemWrite;
   logic                 RegWrite;
   logic                 IRWrite;
   logic                 AdrSrc;
   logic [1:0]           RegSrc;
   logic [1:0]           ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic [1:0]           ResultSrc;
   logic [1:0]           ImmSrc;
   logic [ALUCTL_W-1:0]  ALUControl;
   logic                 LinkWrite;
   logic                 Fault;

   modport master (
      input  Instr, ALUFlags, MemReady,
      output MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, LinkWrite, Fault
   );

   modport slave (
      output Instr, ALUFlags, MemReady,
      input  MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, LinkWrite, Fault
   );
endinterface

// File: rtl/arm_condlogic.sv
// ----------------------------------------------------------------------------
// arm_condlogic
//   NZCV flag register, condition evaluation and CondEx gating of the
//   conditional write enables.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     cond                Instr[31:28]
//     alu_flags           N,Z,C,V from the ALU this cycle
//     flag_w_nz/cv        request to update NZ / CV (ungated)
//     reg_w, mem_w,
//     br_w, link_w        ungated write requests from the FSM
//     reg_write, ...      the same requests qualified by CondEx
// ----------------------------------------------------------------------------
module arm_condlogic
   import arm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic       flag_w_nz,
   input  logic       flag_w_cv,
   input  logic       reg_w,
   input  logic       mem_w,
   input  logic       br_w,
   input  logic       link_w,
   output logic       reg_write,
   output logic       mem_write,
   output logic       br_write,
   output logic       link_write
);

   logic [3:0] flags;      // {N,Z,C,V}
   logic       cond_ex;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= '0;
      end else begin
         if (flag_w_nz && cond_ex) flags[3:2] <= alu_flags[3:2];
         if (flag_w_cv && cond_ex) flags[1:0] <= alu_flags[1:0];
      end
   end

   // NOTE: combinational blocks assign a default first so no path leaves the
   // output unassigned, which would otherwise infer a latch.
   always_comb begin
      cond_ex = 1'b1;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         default: cond_ex = 1'b1;   // AL, and NV treated as AL
      endcase
   end

   assign reg_write  = reg_w  & cond_ex;
   assign mem_write  = mem_w  & cond_ex;
   assign br_write   = br_w   & cond_ex;
   assign link_write = link_w & cond_ex;

endmodule

// File: rtl/arm_mc_controller.sv
// ----------------------------------------------------------------------------
// arm_mc_controller
//   Multicycle ARM control unit: main FSM, ALU decoder, memory ready
//   handshake with a wait-state watchdog, and the condition unit.
//   Parameters: ALUCTL_W (2 or 3), WAIT_W (wait counter width),
//               TIMEOUT (wait cycles before FAULT, < 2**WAIT_W).
//   Ports:
//     clk    clock
//     reset  synchronous active-high reset
//     bus    arm_mc_controller_if.master (Instr, ALUFlags, MemReady in;
//            all datapath control pins, LinkWrite and Fault out)
//   Build option: define ARM_BL_EN to enable branch-with-link (LinkWrite and
//   RegWrite alongside PCWrite for BRANCH with Instr[24]). Without it
//   LinkWrite is 0 and B/BL behave identically.
// ----------------------------------------------------------------------------
module arm_mc_controller
   import arm_pkg::*;
#(
   parameter int ALUCTL_W = 3,
   parameter int WAIT_W   = 8,
   parameter int TIMEOUT  = 200
) (
   input  logic                 clk,
   input  logic                 reset,
   arm_mc_controller_if.master  bus
);

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

   // Instruction fields
   logic [1:0] op;
   logic       i_bit;
   logic [3:0] cmd;
   logic       s_l_bit;     // S for data processing, L for memory
   logic       is_cmp;
   alu_op_t    dp_op;
   logic       unused_instr_bits;

   assign op      = bus.Instr[27:26];
   assign i_bit   = bus.Instr[25];
   assign cmd     = bus.Instr[24:21];
   assign s_l_bit = bus.Instr[20];
   assign is_cmp  = (cmd == CMD_CMP);
   assign dp_op   = alu_decode(cmd, ALUCTL_W >= 3);
   assign unused_instr_bits = ^bus.Instr[19:12];

   // Raw FSM requests; conditional ones are qualified in arm_condlogic
   logic       mem_req, next_pc, ir_write;
   logic       reg_w, mem_w, br_w, link_w, flag_w_nz, flag_w_cv;
   logic       adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   alu_op_t    alu_op;
   logic       reg_write, mem_write, br_write, link_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      next_pc    = 1'b0;
      ir_write   = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      br_w       = 1'b0;
      link_w     = 1'b0;
      flag_w_nz  = 1'b0;
      flag_w_cv  = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRCA_REG;
      alu_src_b  = SRCB_WDATA;
      result_src = RES_ALUOUT;
      alu_op     = ALU_ADD;

      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            if (bus.MemReady) begin
               ir_write  = 1'b1;
               next_pc   = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_FOUR;
            case (op)
               OP_DP:   state_nxt = i_bit ? S_EXECI : S_EXECR;
               OP_MEM:  state_nxt = S_MEMADR;
               OP_BR:   state_nxt = S_BRANCH;
               default: state_nxt = S_FETCH;   // undefined op: drop it
            endcase
         end
         S_MEMADR: begin
            alu_src_b = SRCB_IMM;
            state_nxt = s_l_bit ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.MemReady) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_w      = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEMWR: begin
            // A failed condition still completes the access, without the strobe.
            mem_req = 1'b1;
            adr_src = 1'b1;
            mem_w   = 1'b1;
            if (bus.MemReady) state_nxt = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            alu_src_b = (state == S_EXECI) ? SRCB_IMM : SRCB_WDATA;
            alu_op    = dp_op;
            flag_w_nz = s_l_bit;
            // Carry/overflow only mean something for the arithmetic ops.
            flag_w_cv = s_l_bit && (dp_op == ALU_ADD || dp_op == ALU_SUB);
            state_nxt = is_cmp ? S_FETCH : S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_w      = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_IMM;
            result_src = RES_ALURESULT;
            br_w       = 1'b1;
`ifdef ARM_BL_EN
            link_w     = bus.Instr[24];
            reg_w      = bus.Instr[24];
`endif
            state_nxt  = S_FETCH;
         end
         S_FAULT: begin
            state_nxt = S_FAULT;   // only reset leaves
         end
         default: begin
            state_nxt = S_FETCH;
         end
      endcase

      // Watchdog: the TIMEOUT-th consecutive unanswered request faults.
      if (mem_req && !bus.MemReady && wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
         state_nxt = S_FAULT;
      end

      // Count only while stalled in the same state; ready or leaving clears.
      if (mem_req && !bus.MemReady && state_nxt == state) begin
         wait_cnt_nxt = wait_cnt + 1'b1;
      end else begin
         wait_cnt_nxt = '0;
      end
   end

   arm_condlogic u_condlogic (
      .clk        (clk),
      .reset      (reset),
      .cond       (bus.Instr[31:28]),
      .alu_flags  (bus.ALUFlags),
      .flag_w_nz  (flag_w_nz),
      .flag_w_cv  (flag_w_cv),
      .reg_w      (reg_w),
      .mem_w      (mem_w),
      .br_w       (br_w),
      .link_w     (link_w),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .br_write   (br_write),
      .link_write (link_write)
   );

   // Enables are forced low during reset so an in-flight access is dropped.
   assign bus.MemReq     = mem_req    & ~reset;
   assign bus.PCWrite    = (next_pc | br_write) & ~reset;
   assign bus.MemWrite   = mem_write  & ~reset;
   assign bus.RegWrite   = reg_write  & ~reset;
   assign bus.IRWrite    = ir_write   & ~reset;
   assign bus.LinkWrite  = link_write & ~reset;
   assign bus.Fault      = (state == S_FAULT);

   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUControl = ALUCTL_W'(alu_op);
   assign bus.ImmSrc     = op;
   assign bus.RegSrc     = {(op == OP_MEM) && !s_l_bit, op == OP_BR};

endmodule

// File: tb/tb_arm_mc_controller.sv
// ----------------------------------------------------------------------------
// tb_arm_mc_controller
//   Instruction-level reference model of the multicycle controller. Each
//   instruction is walked through its phases with chosen wait-state counts;
//   every cycle the expected enables (and the mux selects the phase defines)
//   are compared against a 3-bit-ALU instance, and a 2-bit-ALU instance
//   sharing the same inputs is checked for its ALUControl decode.
// ----------------------------------------------------------------------------
module tb_arm_mc_controller;

   localparam int TIMEOUT = 200;

   typedef enum int {
      PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB, PH_MEMWR,
      PH_EXECR, PH_EXECI, PH_ALUWB, PH_BRANCH, PH_FAULT
   } phase_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   arm_mc_controller_if #(.ALUCTL_W(3)) bus3 ();
   arm_mc_controller_if #(.ALUCTL_W(2)) bus2 ();

   assign bus2.Instr    = bus3.Instr;
   assign bus2.ALUFlags = bus3.ALUFlags;
   assign bus2.MemReady = bus3.MemReady;

   arm_mc_controller #(.ALUCTL_W(3), .WAIT_W(8), .TIMEOUT(TIMEOUT)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3)
   );
   arm_mc_controller #(.ALUCTL_W(2), .WAIT_W(8), .TIMEOUT(TIMEOUT)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  flags_m = 4'b0000;   // model NZCV
   logic [31:12] instr  = '0;
   bit          fixed_en = 1'b0;
   logic [3:0]  fixed_flags = 4'b0000;
   logic [3:0]  cmds [8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100,
                            4'b1010, 4'b0001, 4'b1110, 4'b1101};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom);
   endfunction

   // Condition rule: pairs of codes test one predicate, odd code inverts.
   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, r;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0: r = z;
         3'd1: r = c;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = c && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (cond[0] && cond[3:1] != 3'd7) r = !r;
      return r;
   endfunction

   function automatic logic [2:0] exp_alu(input logic [3:0] cmd, input bit wide);
      case (cmd)
         4'b0100:          return 3'b000;
         4'b0010, 4'b1010: return 3'b001;
         4'b0000:          return 3'b010;
         4'b1100:          return 3'b011;
         4'b0001:          return wide ? 3'b100 : 3'b000;
         4'b1110:          return wide ? 3'b101 : 3'b000;
         4'b1101:          return wide ? 3'b110 : 3'b000;
         default:          return 3'b000;
      endcase
   endfunction

   // One clock cycle in the given phase.
   task automatic step(input phase_t ph, input logic rdy);
      logic       e_req, e_pc, e_mw, e_rw, e_ir, e_lk, e_ft;
      logic       e_adr;
      logic [1:0] e_a, e_b, e_res;
      logic [2:0] e_alu, alu2_exp;
      logic       m_adr, m_a, m_b, m_res, m_alu;
      logic [9:0] mask, sel_act, sel_exp;
      logic [6:0] en_act, en_exp;
      logic [3:0] af, cmd;
      logic       c, logical;

      @(negedge clk);
      bus3.Instr    = instr;
      bus3.MemReady = rdy;
      af = fixed_en ? fixed_flags : 4'($urandom);
      bus3.ALUFlags = af;
      #1;

      c   = cond_ok(instr[31:28], flags_m);
      cmd = instr[24:21];
      {e_req, e_pc, e_mw, e_rw, e_ir, e_lk, e_ft} = '0;
      e_adr = 1'b0; e_a = 2'b00; e_b = 2'b00; e_res = 2'b00; e_alu = 3'b000;
      {m_adr, m_a, m_b, m_res, m_alu} = '0;

      case (ph)
         PH_FETCH: begin
            e_req = 1'b1; e_pc = rdy; e_ir = rdy;
            e_adr = 1'b0; e_a = 2'b01; e_b = 2'b10; e_res = 2'b10; e_alu = 3'b000;
            {m_adr, m_a, m_b, m_res, m_alu} = '1;
         end
         PH_DECODE: begin
            e_a = 2'b01; e_b = 2'b10; e_alu = 3'b000;
            m_a = 1'b1; m_b = 1'b1; m_alu = 1'b1;
         end
         PH_MEMADR: begin
            e_b = 2'b01; e_alu = 3'b000; m_b = 1'b1; m_alu = 1'b1;
         end
         PH_MEMRD: begin
            e_req = 1'b1; e_adr = 1'b1; m_adr = 1'b1;
         end
         PH_MEMWB: begin
            e_rw = c; e_res = 2'b01; m_res = 1'b1;
         end
         PH_MEMWR: begin
            e_req = 1'b1; e_mw = c; e_adr = 1'b1; m_adr = 1'b1;
         end
         PH_EXECR, PH_EXECI: begin
            e_b = (ph == PH_EXECI) ? 2'b01 : 2'b00;
            e_alu = exp_alu(cmd, 1'b1);
            m_b = 1'b1; m_alu = 1'b1;
         end
         PH_ALUWB: begin
            e_rw = c; e_res = 2'b00; m_res = 1'b1;
         end
         PH_BRANCH: begin
            e_pc = c;
`ifdef ARM_BL_EN
            e_lk = c & instr[24];
            e_rw = c & instr[24];
`endif
            e_a = 2'b01; e_b = 2'b01; e_res = 2'b10; e_alu = 3'b000;
            {m_a, m_b, m_res, m_alu} = '1;
         end
         default: e_ft = 1'b1;   // PH_FAULT
      endcase

      en_exp  = {e_req, e_pc, e_mw, e_rw, e_ir, e_lk, e_ft};
      en_act  = {bus3.MemReq, bus3.PCWrite, bus3.MemWrite, bus3.RegWrite,
                 bus3.IRWrite, bus3.LinkWrite, bus3.Fault};
      check($sformatf("%s_en", ph.name()), 32'(en_act), 32'(en_exp));

      mask    = {m_adr, {2{m_a}}, {2{m_b}}, {2{m_res}}, {3{m_alu}}};
      sel_exp = {e_adr, e_a, e_b, e_res, e_alu};
      sel_act = {bus3.AdrSrc, bus3.ALUSrcA, bus3.ALUSrcB, bus3.ResultSrc, bus3.ALUControl};
      if (mask != '0) check($sformatf("%s_sel", ph.name()), 32'(sel_act & mask), 32'(sel_exp & mask));

      if (ph == PH_DECODE) check("immsrc", 32'(bus3.ImmSrc), 32'(instr[27:26]));

      if (ph == PH_EXECR || ph == PH_EXECI) begin
         alu2_exp = exp_alu(cmd, 1'b0);
         check("alu2_ctl", 32'(bus2.ALUControl), 32'(alu2_exp[1:0]));
         // Flag update at the end of the execute cycle.
         logical = (cmd == 4'b0000 || cmd == 4'b1100 || cmd == 4'b0001 ||
                    cmd == 4'b1110 || cmd == 4'b1101);
         if (instr[20] && c) begin
            flags_m[3:2] = af[3:2];
            if (!logical) flags_m[1:0] = af[1:0];
         end
      end
   endtask

   // Memory phase: 'waits' cycles not ready, then a ready cycle unless the
   // watchdog has fired.
   task automatic access(input phase_t ph, input int waits, output bit faulted);
      faulted = 1'b0;
      for (int i = 0; i < waits && i < TIMEOUT; i++) step(ph, 1'b0);
      if (waits >= TIMEOUT) faulted = 1'b1;
      else                  step(ph, 1'b1);
   endtask

   task automatic run_instr(input logic [31:12] ins, input int fw, input int mw, output bit faulted);
      bit f;
      instr   = ins;
      faulted = 1'b0;
      access(PH_FETCH, fw, f);
      if (f) begin
         faulted = 1'b1;
         return;
      end
      step(PH_DECODE, rnd_bit());
      case (ins[27:26])
         2'b00: begin
            step(ins[25] ? PH_EXECI : PH_EXECR, rnd_bit());
            if (ins[24:21] != 4'b1010) step(PH_ALUWB, rnd_bit());
         end
         2'b01: begin
            step(PH_MEMADR, rnd_bit());
            if (ins[20]) begin
               access(PH_MEMRD, mw, f);
               if (!f) step(PH_MEMWB, rnd_bit());
            end else begin
               access(PH_MEMWR, mw, f);
            end
            faulted = f;
         end
         2'b10: step(PH_BRANCH, rnd_bit());
         default: ;
      endcase
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus3.MemReady = rnd_bit();
      #1;
      check("reset_en", 32'({bus3.MemReq, bus3.PCWrite, bus3.MemWrite, bus3.RegWrite,
                             bus3.IRWrite, bus3.LinkWrite}), 32'(0));
      @(posedge clk);
      #1;
      reset   = 1'b0;
      flags_m = 4'b0000;
   endtask

   task automatic fault_then_reset();
      for (int i = 0; i < 3; i++) step(PH_FAULT, rnd_bit());
      do_reset();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      bit f;
      bus3.Instr    = '0;
      bus3.MemReady = 1'b0;
      bus3.ALUFlags = 4'b0000;
      do_reset();

      // ADD R1,R2,#5, memory always ready
      run_instr(20'hE2821, 0, 0, f);
      // LDR with 3 fetch and 2 read wait states
      run_instr(20'hE5910, 3, 2, f);

      // SUBS producing Z=1, then BEQ taken
      fixed_en = 1'b1; fixed_flags = 4'b0100;
      run_instr(20'hE2511, 0, 0, f);
      fixed_en = 1'b0;
      run_instr(20'h0A000, 0, 0, f);
      // SUBS producing Z=0, then BEQ not taken
      fixed_en = 1'b1; fixed_flags = 4'b0000;
      run_instr(20'hE2511, 0, 0, f);
      fixed_en = 1'b0;
      run_instr(20'h0A000, 0, 0, f);

      // EOR register form (wide: 100, narrow: ADD)
      run_instr(20'hE0210, 0, 0, f);
      // BL, cond AL
      run_instr(20'hEB000, 0, 0, f);

      // Longest stall that must not fault
      run_instr(20'hE5810, 1, TIMEOUT - 1, f);

      // Reset in the middle of a stalled fetch
      instr = 20'hE2821;
      step(PH_FETCH, 1'b0);
      step(PH_FETCH, 1'b0);
      do_reset();
      run_instr(20'hE2821, 0, 0, f);

      // Randomized instruction stream
      for (int k = 0; k < 300; k++) begin
         logic [31:12] r;
         r = 20'($urandom);
         if ($urandom_range(0, 3) != 0) r[24:21] = cmds[$urandom_range(0, 7)];
         run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3), f);
      end

      // STR never acknowledged -> FAULT, then reset recovers
      run_instr(20'hE5810, 0, TIMEOUT, f);
      fault_then_reset();
      run_instr(20'hE2821, 0, 0, f);

      // Fetch never acknowledged -> FAULT
      run_instr(20'hE2821, TIMEOUT, 0, f);
      fault_then_reset();
      run_instr(20'hE5910, 1, 1, f);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
